// File: rtl/tsn_transmission_selector.sv
// Strict-priority TSN egress selector: arbitrates per-class AXI-Stream inputs under
// per-class gates, forwards one whole frame at a time and truncates overlong frames.

module tsn_ts_frame_ctr (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);
   logic [31:0] count_q, count_d;

   always_comb count_d = inc ? count_q + 32'd1 : count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
endmodule

module tsn_transmission_selector #(
   parameter int N_CLASS       = 4,
   parameter int MAX_FRAME_LEN = 1522,
   localparam int GW           = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CLASS-1:0]     gate_open,
   input  logic [8*N_CLASS-1:0]   s_axis_tdata,
   input  logic [N_CLASS-1:0]     s_axis_tvalid,
   input  logic [N_CLASS-1:0]     s_axis_tlast,
   input  logic [N_CLASS-1:0]     s_axis_tuser,
   output logic [N_CLASS-1:0]     s_axis_tready,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   busy,
   output logic [GW-1:0]          grant_class,
   output logic [32*N_CLASS-1:0]  frame_count,
   output logic [31:0]            trunc_count
);
   typedef enum logic [1:0] {IDLE, TRANSMIT, DROP} state_e;

   state_e                   state_q, state_d;
   logic [GW-1:0]            grant_q, grant_d;
   logic [15:0]              beat_cnt_q, beat_cnt_d;
   logic [31:0]              trunc_count_q, trunc_count_d;
   logic [N_CLASS-1:0]       eligible, frame_inc;
   logic [N_CLASS-1:0][31:0] frame_cnt;
   logic [N_CLASS-1:0][7:0]  s_data;
   logic [GW-1:0]            pick;
   logic [7:0]               g_data;
   logic                     g_valid, g_last, g_user, force_trunc;

   assign s_data   = s_axis_tdata;
   assign eligible = s_axis_tvalid & gate_open;

   // Ascending scan so the highest eligible index wins.
   always_comb begin
      pick = '0;
      for (int i = 0; i < N_CLASS; i++)
         if (eligible[i]) pick = GW'(i);
   end

   assign g_data  = s_data[grant_q];
   assign g_valid = s_axis_tvalid[grant_q];
   assign g_last  = s_axis_tlast[grant_q];
   assign g_user  = s_axis_tuser[grant_q];

   // Last permitted beat of a frame that has not ended yet: cut it here and mark it bad.
   assign force_trunc = (beat_cnt_q == 16'(MAX_FRAME_LEN - 1)) && !g_last;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      beat_cnt_d    = beat_cnt_q;
      trunc_count_d = trunc_count_q;
      frame_inc     = '0;
      s_axis_tready = '0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|eligible) begin
               grant_d    = pick;
               beat_cnt_d = '0;
               state_d    = TRANSMIT;
            end
         end
         TRANSMIT: begin
            m_axis_tdata           = g_data;
            m_axis_tvalid          = g_valid;
            m_axis_tlast           = g_last | force_trunc;
            m_axis_tuser           = g_user | force_trunc;
            s_axis_tready[grant_q] = m_axis_tready;
            if (g_valid && m_axis_tready) begin
               beat_cnt_d = beat_cnt_q + 16'd1;
               if (g_last) begin
                  frame_inc[grant_q] = 1'b1;
                  state_d            = IDLE;
               end else if (force_trunc) begin
                  trunc_count_d = trunc_count_q + 32'd1;
                  state_d       = DROP;
               end
            end
         end
         DROP: begin
            // Swallow the remainder of the oversize frame without forwarding it.
            s_axis_tready[grant_q] = 1'b1;
            if (g_valid && g_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         beat_cnt_q    <= '0;
         trunc_count_q <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         beat_cnt_q    <= beat_cnt_d;
         trunc_count_q <= trunc_count_d;
      end
   end

   for (genvar i = 0; i < N_CLASS; i++) begin : g_cls
      tsn_ts_frame_ctr u_ctr (
         .clk   (clk),
         .rst   (rst),
         .inc   (frame_inc[i]),
         .count (frame_cnt[i])
      );
   end

   assign busy        = (state_q != IDLE);
   assign grant_class = grant_q;
   assign frame_count = frame_cnt;
   assign trunc_count = trunc_count_q;
endmodule

// File: tb/tb_tsn_transmission_selector.sv
// Randomized scoreboard bench for tsn_transmission_selector; each data byte carries
// its class id in [7:6] so the monitor can route beats to per-class expected queues.

module tb_tsn_transmission_selector;
   localparam int NC   = 4;
   localparam int MAXL = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } beat_t;

   logic            clk, rst;
   logic [NC-1:0]   gate_open;
   logic [8*NC-1:0] s_axis_tdata;
   logic [NC-1:0]   s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
   logic [7:0]      m_axis_tdata;
   logic            m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
   logic            busy;
   logic [1:0]      grant_class;
   logic [32*NC-1:0] frame_count;
   logic [31:0]     trunc_count;

   tsn_transmission_selector #(.N_CLASS(NC), .MAX_FRAME_LEN(MAXL)) dut (
      .clk(clk), .rst(rst), .gate_open(gate_open),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .busy(busy), .grant_class(grant_class),
      .frame_count(frame_count), .trunc_count(trunc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    total = 0, bad = 0;
   beat_t src_q[NC][$];
   beat_t exp_q[NC][$];
   int    exp_frames[NC];
   int    exp_trunc;
   logic [NC-1:0] hold, hs;
   int    rdy_pct;
   bit    gate_rand;

   // monitor state
   int    order_log[$];
   int    gap_log[$];
   int    cyc = 0, last_end = -1, cur_cls = 0, nbeat = 0;
   bit    in_frame = 0, stalled = 0;
   beat_t stall_beat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: a frame of len beats yields min(len, MAXL) output beats; if it
   // overruns, the MAXL-th beat is forced to last+user and the frame counts as truncated.
   task automatic send_frame(input int c, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = {2'(c), 6'($urandom)};
         b.last = (k == len - 1);
         b.user = ($urandom_range(9) == 0);
         src_q[c].push_back(b);
         if (k < MAXL) begin
            if (k == MAXL - 1 && !b.last) begin
               b.last = 1'b1;
               b.user = 1'b1;
            end
            exp_q[c].push_back(b);
         end
      end
      if (len <= MAXL) exp_frames[c]++;
      else             exp_trunc++;
   endtask

   function automatic bit pending();
      pending = 1'b0;
      for (int i = 0; i < NC; i++)
         if (src_q[i].size() != 0 || exp_q[i].size() != 0) pending = 1'b1;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((pending() || busy) && n < budget) begin
         tick(1);
         n++;
      end
      check(name, 32'(n < budget), 32'd1);
   endtask

   task automatic check_counts(input string name);
      for (int i = 0; i < NC; i++)
         check($sformatf("%s_frames%0d", name, i), frame_count[32*i +: 32], 32'(exp_frames[i]));
      check({name, "_trunc"}, trunc_count, 32'(exp_trunc));
   endtask

   task automatic clear_logs();
      order_log.delete();
      gap_log.delete();
      last_end = -1;
   endtask

   // Source driver: retire beats handshaken on the previous edge, then present heads.
   always @(posedge clk) begin
      logic [8*NC-1:0] d;
      #1;
      d = '0;
      for (int i = 0; i < NC; i++) begin
         if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
         if (src_q[i].size() != 0 && !hold[i]) begin
            s_axis_tvalid[i] = 1'b1;
            d[8*i +: 8]      = src_q[i][0].data;
            s_axis_tlast[i]  = src_q[i][0].last;
            s_axis_tuser[i]  = src_q[i][0].user;
         end else begin
            s_axis_tvalid[i] = 1'b0;
            s_axis_tlast[i]  = 1'b0;
            s_axis_tuser[i]  = 1'b0;
         end
      end
      s_axis_tdata  = d;
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      if (gate_rand) gate_open = 4'($urandom);
   end

   // Monitor: sample mid-cycle, so a handshake seen here completes on the next edge.
   always @(negedge clk) begin
      beat_t got, want;
      int    tag;
      cyc++;
      hs = s_axis_tvalid & s_axis_tready;
      if (rst) begin
         in_frame = 0;
         stalled  = 0;
      end else begin
         got = '{data: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser};
         if (stalled) begin
            check("stall_valid", 32'(m_axis_tvalid), 32'd1);
            check("stall_beat", 32'(got), 32'(stall_beat));
         end
         stalled    = m_axis_tvalid && !m_axis_tready;
         stall_beat = got;
         if (m_axis_tvalid && m_axis_tready) begin
            tag = int'(m_axis_tdata[7:6]);
            check("grant_class", 32'(grant_class), 32'(tag));
            if (!in_frame) begin
               order_log.push_back(tag);
               if (last_end >= 0) gap_log.push_back(cyc - last_end);
               cur_cls  = tag;
               in_frame = 1;
               nbeat    = 0;
            end else begin
               check("interleave", 32'(tag), 32'(cur_cls));
            end
            nbeat++;
            if (exp_q[tag].size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h want none (class %0d)", got, tag);
            end else begin
               want = exp_q[tag].pop_front();
               check("beat", 32'(got), 32'(want));
            end
            if (m_axis_tlast) begin
               in_frame = 0;
               last_end = cyc;
            end
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; hold = '0; hs = '0; gate_open = '1; gate_rand = 0; rdy_pct = 100;
      s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
      m_axis_tready = 1'b0; exp_trunc = 0;
      for (int i = 0; i < NC; i++) exp_frames[i] = 0;

      tick(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_sready", 32'(s_axis_tready), 32'd0);
      check("rst_grant", 32'(grant_class), 32'd0);
      check_counts("rst");
      rst = 1'b0;
      tick(2);

      // Two classes pending together: higher class first, one idle cycle, then lower.
      clear_logs();
      hold = '1;
      send_frame(0, 12);
      send_frame(2, 12);
      tick(2);
      hold = '0;
      drain("prio_drain", 200);
      check("prio_n", 32'(order_log.size()), 32'd2);
      check("prio_first", 32'(order_log.size() > 0 ? order_log[0] : -1), 32'd2);
      check("prio_second", 32'(order_log.size() > 1 ? order_log[1] : -1), 32'd0);
      check("prio_gap", 32'(gap_log.size() > 0 ? gap_log[0] : -1), 32'd2);
      check_counts("prio");

      // Higher class arriving mid-frame waits for the frame end.
      clear_logs();
      send_frame(1, 14);
      tick(5);
      send_frame(3, 5);
      drain("lock_drain", 200);
      check("lock_first", 32'(order_log.size() > 0 ? order_log[0] : -1), 32'd1);
      check("lock_second", 32'(order_log.size() > 1 ? order_log[1] : -1), 32'd3);

      // Closed gate on class 3: class 0 goes, class 3 waits until its gate opens.
      clear_logs();
      gate_open = 4'b0111;
      hold = '1;
      send_frame(3, 6);
      send_frame(0, 6);
      tick(2);
      hold = '0;
      tick(30);
      check("gate_n", 32'(order_log.size()), 32'd1);
      check("gate_first", 32'(order_log.size() > 0 ? order_log[0] : -1), 32'd0);
      check("gate_held", 32'(exp_q[3].size()), 32'd6);
      check("gate_idle", 32'(busy), 32'd0);
      gate_open = '1;
      drain("gate_drain", 200);
      check("gate_second", 32'(order_log.size() > 1 ? order_log[1] : -1), 32'd3);

      // Length boundaries around MAXL.
      send_frame(1, 20);
      drain("trunc20", 200);
      check_counts("trunc20");
      send_frame(2, MAXL);
      drain("exact", 200);
      send_frame(3, MAXL + 1);
      send_frame(0, MAXL - 1);
      drain("edge", 200);
      check_counts("len_edges");

      // Random traffic, 30% sink ready, gates toggling.
      rdy_pct = 30;
      gate_rand = 1;
      for (int f = 0; f < 100; f++) begin
         send_frame(int'($urandom_range(NC - 1)), int'($urandom_range(1, 24)));
         tick(int'($urandom_range(0, 15)));
      end
      drain("rand_drain", 30000);
      gate_rand = 0;
      gate_open = '1;
      rdy_pct = 100;
      tick(2);
      check_counts("rand");

      // Reset in the middle of a frame.
      send_frame(1, 20);
      n = 0;
      while (nbeat < 10 && n < 100) begin
         tick(1);
         n++;
      end
      check("rst_wait", 32'(n < 100), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_out", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy}), 32'd0);
      check("mid_rst_sready", 32'(s_axis_tready), 32'd0);
      for (int i = 0; i < NC; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
         exp_frames[i] = 0;
      end
      exp_trunc = 0;
      check_counts("mid_rst");
      tick(1);
      send_frame(0, 5);
      tick(2);
      rst = 1'b0;
      tick(1);
      check("post_rst_arb", 32'(busy), 32'd1);
      drain("post_rst", 200);
      check_counts("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
